apb_xfer_ctrl: RTL and testbench
================================

Name: apb_xfer_ctrl

Overview:
APB master-side sequencer that drives the APB slave interface block. It accepts single read/write requests from the AHB-side bridge logic through a one-entry request buffer. It decodes the address to a one-hot Pselx, runs the APB SETUP/ACCESS protocol, captures Prdata and returns a one-cycle response pulse.

Parameters:
SLV0_BASE, 32'h8000_0000, base of slave 0 window (64 MB, address bits [25:0] free)
SLV1_BASE, 32'h8400_0000, base of slave 1 window (64 MB)
SLV2_BASE, 32'h8800_0000, base of slave 2 window (64 MB)
RD_DELAY, 1, read-capture delay after ACCESS; legal values 0 or 1
TIMEOUT, 16, max ACCESS wait cycles (only used with PREADY_EN)

Ports:
Hclk  in  1  system clock, all logic on posedge
Hreset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request buffer empty; accept on req_valid&&req_ready
req_write  in  1  1=write, 0=read
req_addr  in  32  request address
req_wdata  in  32  write data
rsp_valid  out  1  one-cycle response pulse
rsp_err  out  1  qualifies rsp_valid: decode miss or timeout
rsp_rdata  out  32  read data; 0 for writes and errors
busy  out  1  FSM not in IDLE or buffer full
Pselx  out  3  one-hot slave select
Penable  out  1  APB enable
Pwrite  out  1  APB direction
Paddr  out  32  APB address
Pwdata  out  32  APB write data
Prdata  in  32  APB read data

Behaviour:
- Reset (async, immediate): state IDLE, buffer empty, req_ready=1, all other outputs 0. A transfer in flight is dropped and produces no response.
- Buffer: one entry. Loaded on req_valid&&req_ready; freed on the edge entering SETUP. req_ready=!buffer_full, registered.
- Decode: exactly one slave hit when req_addr[31:26] matches base[31:26]. Otherwise a miss.
- FSM states: IDLE, SETUP, ACCESS, CAPTURE, RESP.
- IDLE, buffer full, decode hit -> SETUP. Drive Pselx one-hot, Paddr, Pwrite, Pwdata (0 for reads), Penable=0.
- IDLE, buffer full, decode miss -> RESP with rsp_err=1. No APB activity. Buffer is freed.
- SETUP -> ACCESS unconditionally: Penable=1, all other APB outputs held stable.
- ACCESS exit for writes and for reads with RD_DELAY=0 -> RESP. Reads with RD_DELAY=0 sample Prdata on the ACCESS exit edge.
- ACCESS exit for reads with RD_DELAY=1 -> CAPTURE. In CAPTURE, Pselx=0 and Penable=0; Prdata is sampled on the CAPTURE exit edge. Next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle. Pselx, Penable and Pwrite are 0 in RESP, CAPTURE and IDLE.
- RESP with buffer full goes directly to SETUP (or to RESP again on a miss); otherwise -> IDLE. No response backpressure.
- Latency from acceptance edge to rsp_valid: write 4 cycles, read 4 (RD_DELAY=0) or 5 (RD_DELAY=1), decode miss 2.
- A request may be accepted in any state while the buffer is empty, including the same cycle the buffer frees.

Optional Feature:
APB_PREADY_EN defined:
- Adds input Pready (1 bit).
- ACCESS holds while Pready=0, with all APB outputs stable.
- A wait counter increments each stalled cycle. Reaching TIMEOUT -> RESP with rsp_err=1 and rsp_rdata=0.
- The counter clears on entering ACCESS.
APB_PREADY_EN undefined: no Pready port, and ACCESS lasts exactly one cycle.

Test Plan:
- Write 0x8400_0010 / 0xDEAD_BEEF -> Pselx=3'b010 in SETUP; Penable=1 in next cycle; rsp_valid, rsp_err=0 four cycles after accept.
- Read 0x8800_0004 with slave returning Prdata=0x5A one cycle after ACCESS (RD_DELAY=1) -> Pselx=3'b100, Pwrite=0, rsp_rdata=0x0000_005A.
- Read 0x9000_0000 -> no Pselx/Penable activity; rsp_valid=1 with rsp_err=1 two cycles after accept.
- Two writes presented back-to-back to slave 0 -> second accepted while first is in SETUP; second SETUP directly follows first RESP; two rsp_valid pulses 3 cycles apart.
- Hreset asserted during ACCESS -> Pselx, Penable and outputs 0 immediately; no rsp_valid; req_ready=1 after release.
- APB_PREADY_EN, TIMEOUT=16, Pready held low -> ACCESS lasts 16 cycles, then rsp_err=1; Pready low 3 cycles then high -> normal response 3 cycles late.

Source files
------------

// File: rtl/apb_xfer_ctrl.sv
// apb_xfer_ctrl: APB master-side sequencer.
// Takes single read/write requests through a one-entry buffer, decodes the
// address to one of three 64 MB slave windows, runs SETUP/ACCESS and returns
// a one-cycle response pulse with read data or an error flag.
// Optional feature macro: APB_PREADY_EN adds a Pready input, ACCESS wait
// states and a TIMEOUT error. Without it ACCESS lasts exactly one cycle.
module apb_xfer_ctrl #(
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
  parameter int          RD_DELAY  = 1,
  parameter int          TIMEOUT   = 16
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic [2:0]  Pselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
`ifdef APB_PREADY_EN
  input  logic        Pready,
`endif
  input  logic [31:0] Prdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        buf_full;
  logic        buf_full_next;
  logic        buf_free;
  logic        buf_write;
  logic [31:0] buf_addr;
  logic [31:0] buf_wdata;
  logic        accept;
  logic [2:0]  hit;

  logic        rsp_err_n;
  logic [31:0] rsp_rdata_n;
  logic        xfer_done;
  logic        timeout;

  // Only the upper six address bits select a window; the rest pass through.
  function automatic logic [2:0] decode(input logic [31:0] addr);
    logic [2:0] sel;
    sel    = 3'b000;
    sel[0] = (addr[31:26] == SLV0_BASE[31:26]);
    sel[1] = (addr[31:26] == SLV1_BASE[31:26]);
    sel[2] = (addr[31:26] == SLV2_BASE[31:26]);
    return sel;
  endfunction

  assign accept = req_valid && req_ready;
  assign hit    = decode(buf_addr);

`ifdef APB_PREADY_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // A stall that would bring the wait count to TIMEOUT ends the transfer.
  assign timeout   = (state == ACCESS) && !Pready && (wait_cnt == CW'(TIMEOUT - 1));
  assign xfer_done = Pready;

  // Wait-state counter: zero outside ACCESS, so every ACCESS starts from zero.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset)
      wait_cnt <= '0;
    else if (state != ACCESS)
      wait_cnt <= '0;
    else if (!Pready)
      wait_cnt <= wait_cnt + CW'(1);
  end
`else
  assign timeout   = 1'b0;
  assign xfer_done = 1'b1;
`endif

  // State register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state decode; also selects what the response will carry.
  always_comb begin
    state_next  = state;
    buf_free    = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_rdata_n = '0;
    case (state)
      IDLE, RESP: begin
        if (buf_full) begin
          buf_free = 1'b1;
          if (hit != 3'b000) begin
            state_next = SETUP;
          end else begin
            state_next = RESP;
            rsp_err_n  = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (timeout) begin
          state_next = RESP;
          rsp_err_n  = 1'b1;
        end else if (xfer_done) begin
          // Pwrite still holds the transfer direction throughout ACCESS.
          if (!Pwrite && (RD_DELAY != 0)) begin
            state_next = CAPTURE;
          end else begin
            state_next = RESP;
            if (!Pwrite)
              rsp_rdata_n = Prdata;
          end
        end
      end
      CAPTURE: begin
        state_next  = RESP;
        rsp_rdata_n = Prdata;
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer occupancy: load and free can never coincide (load needs it empty).
  always_comb begin
    buf_full_next = buf_full;
    if (accept)
      buf_full_next = 1'b1;
    else if (buf_free)
      buf_full_next = 1'b0;
  end

  // Buffer flag, registered ready and busy.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      buf_full  <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      buf_full  <= buf_full_next;
      req_ready <= !buf_full_next;
      busy      <= (state_next != IDLE) || buf_full_next;
    end
  end

  // Buffer payload; qualified by buf_full, so it needs no reset.
  always_ff @(posedge Hclk) begin
    if (accept) begin
      buf_write <= req_write;
      buf_addr  <= req_addr;
      buf_wdata <= req_wdata;
    end
  end

  // APB outputs, registered from the state being entered.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      Pselx   <= '0;
      Penable <= 1'b0;
      Pwrite  <= 1'b0;
      Paddr   <= '0;
      Pwdata  <= '0;
    end else begin
      case (state_next)
        SETUP: begin
          if (state != SETUP) begin
            Pselx   <= hit;
            Paddr   <= buf_addr;
            Pwrite  <= buf_write;
            Pwdata  <= buf_write ? buf_wdata : 32'h0;
            Penable <= 1'b0;
          end
        end
        ACCESS: Penable <= 1'b1;
        default: begin
          Pselx   <= '0;
          Penable <= 1'b0;
          Pwrite  <= 1'b0;
        end
      endcase
    end
  end

  // Response: one pulse per entry into RESP; data is zero unless a read completed.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state_next == RESP);
      rsp_err   <= (state_next == RESP) && rsp_err_n;
      rsp_rdata <= (state_next == RESP) ? rsp_rdata_n : 32'h0;
    end
  end

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Self-checking bench for apb_xfer_ctrl (default parameters, RD_DELAY=1).
// Expected responses go into a scoreboard queue at request time together
// with the cycle index at which a posedge consumer would first see rsp_valid
// (accept edge + latency); a negedge monitor pops and compares them.
module tb_apb_xfer_ctrl;

  logic        Hclk;
  logic        Hreset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
`ifdef APB_PREADY_EN
  logic        Pready;
`endif

  apb_xfer_ctrl dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
`ifdef APB_PREADY_EN
    .Pready    (Pready),
`endif
    .Prdata    (Prdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] rd_val  = 32'h0;
  logic        cap_next = 1'b0;

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  always @(posedge Hclk) cyc <= cyc + 1;

  // Slave model: real data only in the cycle after a read ACCESS, junk otherwise.
  always @(negedge Hclk) begin
    Prdata   = cap_next ? rd_val : 32'hFFFF_FFFF;
    cap_next = (Pselx != 3'b000) && Penable && !Pwrite;
  end

  // Response monitor / scoreboard.
  always @(negedge Hclk) begin
    exp_t e;
    if (!Hreset && rsp_valid === 1'b1) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid at cyc %0d, none expected", cyc);
      end else begin
        e = sbq.pop_front();
        if (rsp_err !== e.err || rsp_rdata !== e.rdata || cyc !== e.at) begin
          n_fail++;
          $display("FAIL rsp: got err=%b rdata=%h cyc=%0d, want err=%b rdata=%h cyc=%0d",
                   rsp_err, rsp_rdata, cyc, e.err, e.rdata, e.at);
        end
      end
    end
  end

  // Issue one request from a negedge; returns the accept edge index.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd, input int lat,
                        input bit push, output int acc);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge Hclk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_ready_wait: req_ready=%b after %0d cycles, want 1", req_ready, n);
      acc = -1;
      return;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    acc = cyc + 1;
    if (push) sbq.push_back('{err: exp_err, rdata: exp_rd, at: acc + lat - 1});
    @(negedge Hclk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge Hclk);
      n++;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, want 0", sbq.size());
      sbq.delete();
    end
    @(negedge Hclk);
  endtask

  task automatic test_reset();
    Hreset = 1'b1;
    repeat (2) @(negedge Hclk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_tests++;
    if ({rsp_valid, rsp_err, busy, Penable, Pwrite} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {rsp_valid, rsp_err, busy, Penable, Pwrite});
    end
    n_tests++;
    if (Pselx !== 3'b000 || Paddr !== 32'h0 || Pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: Pselx=%b Paddr=%h Pwdata=%h rdata=%h want all 0", Pselx, Paddr, Pwdata, rsp_rdata);
    end
    Hreset = 1'b0;
    @(negedge Hclk);
  endtask

  task automatic test_write();
    int acc;
    do_req(1'b1, 32'h8400_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 4, 1'b1, acc);
    @(negedge Hclk);
    n_tests++;
    if (Pselx !== 3'b010 || Penable !== 1'b0 || Pwrite !== 1'b1 || Paddr !== 32'h8400_0010 ||
        Pwdata !== 32'hDEAD_BEEF || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_setup: sel=%b en=%b wr=%b addr=%h wdata=%h busy=%b want 010 0 1 84000010 deadbeef 1",
               Pselx, Penable, Pwrite, Paddr, Pwdata, busy);
    end
    @(negedge Hclk);
    n_tests++;
    if (Pselx !== 3'b010 || Penable !== 1'b1 || Paddr !== 32'h8400_0010) begin
      n_fail++;
      $display("FAIL write_access: sel=%b en=%b addr=%h want 010 1 84000010", Pselx, Penable, Paddr);
    end
    @(negedge Hclk);
    n_tests++;
    if (Pselx !== 3'b000 || Penable !== 1'b0 || Pwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL write_resp_apb: sel=%b en=%b wr=%b want 000 0 0", Pselx, Penable, Pwrite);
    end
    drain();
  endtask

  task automatic test_read();
    int acc;
    rd_val = 32'h0000_005A;
    do_req(1'b0, 32'h8800_0004, 32'h1234_5678, 1'b0, 32'h0000_005A, 5, 1'b1, acc);
    @(negedge Hclk);
    n_tests++;
    if (Pselx !== 3'b100 || Pwrite !== 1'b0 || Pwdata !== 32'h0 || Penable !== 1'b0) begin
      n_fail++;
      $display("FAIL read_setup: sel=%b wr=%b wdata=%h en=%b want 100 0 0 0", Pselx, Pwrite, Pwdata, Penable);
    end
    repeat (2) @(negedge Hclk);
    n_tests++;
    if (Pselx !== 3'b000 || Penable !== 1'b0) begin
      n_fail++;
      $display("FAIL read_capture: sel=%b en=%b want 000 0", Pselx, Penable);
    end
    drain();
    // Window edges: first byte of slave 0 and last word of slave 2.
    rd_val = 32'hA5A5_0001;
    do_req(1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'hA5A5_0001, 5, 1'b1, acc);
    @(negedge Hclk);
    n_tests++;
    if (Pselx !== 3'b001) begin n_fail++; $display("FAIL read_slv0_sel: got %b want 001", Pselx); end
    drain();
    rd_val = 32'h0F0F_C3C3;
    do_req(1'b0, 32'h8BFF_FFFC, 32'h0, 1'b0, 32'h0F0F_C3C3, 5, 1'b1, acc);
    @(negedge Hclk);
    n_tests++;
    if (Pselx !== 3'b100 || Paddr !== 32'h8BFF_FFFC) begin
      n_fail++;
      $display("FAIL read_slv2_top: sel=%b addr=%h want 100 8bfffffc", Pselx, Paddr);
    end
    drain();
  endtask

  task automatic test_miss();
    int acc;
    logic [31:0] miss_addr[3];
    miss_addr[0] = 32'h9000_0000;
    miss_addr[1] = 32'h7FFF_FFFC;
    miss_addr[2] = 32'h8C00_0000;
    for (int i = 0; i < 3; i++) begin
      do_req(i[0], miss_addr[i], 32'hCAFE_0000, 1'b1, 32'h0, 2, 1'b1, acc);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (Pselx !== 3'b000 || Penable !== 1'b0) begin
          n_fail++;
          $display("FAIL miss_apb_idle[%0d]: sel=%b en=%b want 000 0", i, Pselx, Penable);
        end
        @(negedge Hclk);
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2;
    do_req(1'b1, 32'h8000_0100, 32'h1111_1111, 1'b0, 32'h0, 4, 1'b1, acc1);
    // Second cannot enter SETUP until the first leaves RESP: 5 edges after its accept.
    do_req(1'b1, 32'h8000_0104, 32'h2222_2222, 1'b0, 32'h0, 5, 1'b1, acc2);
    n_tests++;
    if (acc2 !== acc1 + 2) begin
      n_fail++;
      $display("FAIL b2b_accept: second accepted at %0d, want %0d", acc2, acc1 + 2);
    end
    @(negedge Hclk);
    n_tests++;
    if (Pselx !== 3'b000) begin n_fail++; $display("FAIL b2b_resp_sel: got %b want 000", Pselx); end
    @(negedge Hclk);
    n_tests++;
    if (Pselx !== 3'b001 || Penable !== 1'b0 || Paddr !== 32'h8000_0104 || Pwdata !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL b2b_setup2: sel=%b en=%b addr=%h wdata=%h want 001 0 80000104 22222222",
               Pselx, Penable, Paddr, Pwdata);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int acc;
    int n = 0;
    do_req(1'b1, 32'h8800_0020, 32'h5555_AAAA, 1'b0, 32'h0, 4, 1'b0, acc);
    while (Penable !== 1'b1 && n < 10) begin
      @(negedge Hclk);
      n++;
    end
    n_tests++;
    if (Penable !== 1'b1) begin n_fail++; $display("FAIL rst_mid_access: Penable=%b want 1", Penable); end
    Hreset = 1'b1;
    #1;
    n_tests++;
    if (Pselx !== 3'b000 || Penable !== 1'b0 || Pwrite !== 1'b0 || Paddr !== 32'h0 || Pwdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_apb: sel=%b en=%b wr=%b addr=%h wdata=%h want all 0", Pselx, Penable, Pwrite, Paddr, Pwdata);
    end
    n_tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ctrl: busy=%b ready=%b rsp=%b want 0 1 0", busy, req_ready, rsp_valid);
    end
    repeat (2) @(negedge Hclk);
    Hreset = 1'b0;
    repeat (6) @(negedge Hclk);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_after: ready=%b busy=%b want 1 0", req_ready, busy);
    end
    do_req(1'b1, 32'h8400_0000, 32'h0BAD_F00D, 1'b0, 32'h0, 4, 1'b1, acc);
    drain();
  endtask

`ifdef APB_PREADY_EN
  task automatic test_pready();
    int acc;
    Pready = 1'b0;
    do_req(1'b1, 32'h8000_0000, 32'h1, 1'b1, 32'h0, 4 + 15, 1'b1, acc);
    drain();
    do_req(1'b1, 32'h8000_0008, 32'h2, 1'b0, 32'h0, 4 + 3, 1'b1, acc);
    while (Penable !== 1'b1) @(negedge Hclk);
    repeat (3) @(negedge Hclk);
    Pready = 1'b1;
    drain();
  endtask
`endif

  initial begin
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
`ifdef APB_PREADY_EN
    Pready    = 1'b1;
`endif
    test_reset();
    test_write();
    test_read();
    test_miss();
    test_back_to_back();
    test_reset_midflight();
`ifdef APB_PREADY_EN
    test_pready();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
